// File: rtl/keypad_scanner_pkg.sv
// Shared types, sizes and small helpers for the keypad scanner.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    // True when exactly one column is asserted (rejects idle and ghosting).
    function automatic logic is_onehot(input logic [NUM_COLS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // One-hot row vector for a row index; bit 0 is the bottom row.
    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_IDX_W-1:0] idx);
        return NUM_ROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Accepted-key bus from the scanner to the downstream decode logic.
interface keypad_scanner_if;
    import kp_pkg::*;

    logic [NUM_ROWS-1:0] key_r;
    logic [NUM_COLS-1:0] key_c;
    logic                key_valid;
    logic                key_held;

    modport master (output key_r, output key_c, output key_valid, output key_held);
    modport slave  (input  key_r, input  key_c, input  key_valid, input  key_held);

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so active-low inputs read as idle.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Bring the asynchronous input into the clk domain through two stages.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and a one-cycle accept strobe.
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] cols_n,
    output logic [NUM_ROWS-1:0] rows_n,
    keypad_scanner_if.master    key_bus
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t            state;
    logic [ROW_IDX_W-1:0]   row_idx;
    logic [ROW_IDX_W-1:0]   next_row;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [DB_W-1:0]        db_cnt;
    logic [NUM_ROWS-1:0]    cand_r;
    logic [NUM_COLS-1:0]    cand_c;
    logic [NUM_COLS-1:0]    cols_sync;
    logic [NUM_COLS-1:0]    cols;
    logic [NUM_ROWS-1:0]    key_r;
    logic [NUM_COLS-1:0]    key_c;
    logic                   key_valid;
    logic                   key_held;

    sync_2ff #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols_n),
        .q     (cols_sync)
    );

    assign cols     = ~cols_sync;
    assign next_row = row_idx + ROW_IDX_W'(1);

    assign key_bus.key_r     = key_r;
    assign key_bus.key_c     = key_c;
    assign key_bus.key_valid = key_valid;
    assign key_bus.key_held  = key_held;

    // Scan/debounce/hold/release controller; every output is registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SCAN;
            row_idx    <= '0;
            rows_n     <= ~row_onehot(ROW_IDX_W'(0));
            settle_cnt <= '0;
            db_cnt     <= '0;
            cand_r     <= '0;
            cand_c     <= '0;
            key_r      <= '0;
            key_c      <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (is_onehot(cols)) begin
                            cand_c <= cols;
                            cand_r <= row_onehot(row_idx);
                            db_cnt <= '0;
                            state  <= DEBOUNCE;
                        end else begin
                            row_idx <= next_row;
                            rows_n  <= ~row_onehot(next_row);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cols == cand_c) begin
                        if (db_cnt == DB_LAST) begin
                            state     <= HELD;
                            key_r     <= cand_r;
                            key_c     <= cand_c;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        state      <= SCAN;
                        settle_cnt <= '0;
                        row_idx    <= next_row;
                        rows_n     <= ~row_onehot(next_row);
                    end
                end
                HELD: begin
                    if ((cols & key_c) == '0) begin
                        state  <= RELEASE;
                        db_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if ((cols & key_c) != '0) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= SCAN;
                        key_held   <= 1'b0;
                        settle_cnt <= '0;
                        row_idx    <= next_row;
                        rows_n     <= ~row_onehot(next_row);
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed presses and a key_valid scoreboard.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic prev_valid = 1'b0;

    keypad_scanner_if kbus ();

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cols_n  (cols_n),
        .rows_n  (rows_n),
        .key_bus (kbus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !rows_n[r]) begin
                    cols_n[c] = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every key_valid must match the next queued key and never repeat back to back.
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] exp;
        if (kbus.key_valid === 1'b1) begin
            got = {kbus.key_r, kbus.key_c};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_valid actual r=%b c=%b required no strobe", kbus.key_r, kbus.key_c);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("[TB] FAIL accepted_key actual r=%b c=%b required r=%b c=%b",
                             got[7:4], got[3:0], exp[7:4], exp[3:0]);
                end
            end
            total++;
            if (prev_valid === 1'b1) begin
                bad++;
                $display("[TB] FAIL valid_back_to_back actual=2 cycles required=1 cycle");
            end
        end
        prev_valid = kbus.key_valid;
    end

    task automatic applyStimulus(input logic [15:0] k);
        keys = k;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitHeld(input logic val, input int limit, input string name);
        int n = 0;
        while (kbus.key_held !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {3'b000, kbus.key_held}, {3'b000, val});
    endtask

    task automatic waitRows(input logic [3:0] val, input int limit, input string name);
        int n = 0;
        while (rows_n !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, rows_n, val);
    endtask

    // Directed test sequence.
    initial begin
        logic [3:0] one;
        logic [3:0] e;
        one   = 4'b0001;
        reset = 1'b0;
        applyStimulus(16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rows", rows_n, 4'b1110);
        checkOutput("rst_key_r", kbus.key_r, 4'b0000);
        checkOutput("rst_key_c", kbus.key_c, 4'b0000);
        checkOutput("rst_valid", {3'b000, kbus.key_valid}, 4'b0000);
        checkOutput("rst_held", {3'b000, kbus.key_held}, 4'b0000);
        reset = 1'b1;

        $display("[TB] idle row rotation");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                e = ~(one << (r % 4));
                checkOutput("scan_rows", rows_n, e);
                @(negedge clk);
            end
        end

        $display("[TB] key 5 press and hold");
        exp_q.push_back({4'b0100, 4'b0010});
        applyStimulus(16'h0200);
        waitHeld(1'b1, 60, "press5_held");
        for (int i = 0; i < 10; i++) begin
            cycles(10);
            checkOutput("press5_rows_frozen", rows_n, 4'b1011);
            checkOutput("press5_still_held", {3'b000, kbus.key_held}, 4'b0001);
        end
        applyStimulus(16'h0000);
        cycles(3);
        checkOutput("release5_debounce_held", {3'b000, kbus.key_held}, 4'b0001);
        waitHeld(1'b0, 40, "release5_done");
        checkOutput("release5_key_r_kept", kbus.key_r, 4'b0100);
        checkOutput("release5_key_c_kept", kbus.key_c, 4'b0010);

        $display("[TB] key A with bounce");
        waitRows(4'b0111, 40, "find_row3");
        applyStimulus(16'h8000);
        cycles(5);
        applyStimulus(16'h0000);
        cycles(2);
        exp_q.push_back({4'b1000, 4'b1000});
        applyStimulus(16'h8000);
        waitHeld(1'b1, 80, "bounceA_held");
        checkOutput("bounceA_key_r", kbus.key_r, 4'b1000);
        checkOutput("bounceA_key_c", kbus.key_c, 4'b1000);

        $display("[TB] release glitch on A");
        applyStimulus(16'h0000);
        cycles(3);
        applyStimulus(16'h8000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("glitch_held", {3'b000, kbus.key_held}, 4'b0001);
        end
        cycles(10);
        checkOutput("glitch_key_r", kbus.key_r, 4'b1000);
        applyStimulus(16'h0000);
        waitHeld(1'b0, 40, "releaseA_done");

        $display("[TB] ghost keys 7 and 8");
        applyStimulus(16'h0030);
        for (int i = 0; i < 6; i++) begin
            cycles(10);
            checkOutput("ghost_not_held", {3'b000, kbus.key_held}, 4'b0000);
        end
        applyStimulus(16'h0000);
        cycles(2);

        $display("[TB] key 3 held, key 5 ignored");
        exp_q.push_back({4'b1000, 4'b0100});
        applyStimulus(16'h4000);
        waitHeld(1'b1, 60, "press3_held");
        applyStimulus(16'h4200);
        cycles(40);
        checkOutput("no_rollover_key_r", kbus.key_r, 4'b1000);
        checkOutput("no_rollover_key_c", kbus.key_c, 4'b0100);
        checkOutput("no_rollover_rows", rows_n, 4'b0111);
        checkOutput("no_rollover_held", {3'b000, kbus.key_held}, 4'b0001);
        applyStimulus(16'h0000);
        waitHeld(1'b0, 40, "release3_done");

        $display("[TB] reset during debounce of key 0");
        waitRows(4'b1110, 40, "find_row0");
        applyStimulus(16'h0002);
        cycles(7);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rows", rows_n, 4'b1110);
        checkOutput("midrst_valid", {3'b000, kbus.key_valid}, 4'b0000);
        checkOutput("midrst_held", {3'b000, kbus.key_held}, 4'b0000);
        checkOutput("midrst_key_r", kbus.key_r, 4'b0000);
        checkOutput("midrst_key_c", kbus.key_c, 4'b0000);
        exp_q.push_back({4'b0001, 4'b0010});
        reset = 1'b1;
        cycles(11);
        checkOutput("latency_early", {3'b000, kbus.key_valid}, 4'b0000);
        cycles(1);
        checkOutput("latency_exact", {3'b000, kbus.key_valid}, 4'b0001);
        checkOutput("key0_key_r", kbus.key_r, 4'b0001);
        checkOutput("key0_key_c", kbus.key_c, 4'b0010);
        applyStimulus(16'h0000);
        waitHeld(1'b0, 40, "release0_done");
        cycles(5);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending_keys actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage for the keypad decode logic. Drives the 4x4 matrix keypad rows one at a time (active-low) and samples the active-low column inputs through a synchronizer.
- Debounces one key press and presents it to the decoder as one-hot row/column vectors, with a single-cycle key_valid strobe per accepted press.
- Downstream display/shift logic consumes key_valid together with the decoded value.

Parameters:
- SETTLE_CYCLES, 4: cycles each row is driven before its columns are sampled.
- DEBOUNCE_CYCLES, 240000: consecutive stable cycles required to accept a press or a release (10 ms at 24 MHz). Benches override this to 8.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- cols_n  input  4  raw keypad columns, active-low, pulled up, asynchronous to clk.
- rows_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_r  output  4  one-hot row of the last accepted key. Bit 3 is the top row (1 2 3 A); bit 0 is the bottom row (E 0 F D).
- key_c  output  4  one-hot column of the last accepted key. Bit 0 is the leftmost column.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  high while the accepted key remains pressed, including release debounce.

Behaviour:
- Reset (reset==0 at a clk edge) applies regardless of state, mid-debounce included:
  - state=SCAN, row_idx=0, rows_n=4'b1110.
  - key_r=0, key_c=0, key_valid=0, key_held=0.
  - All counters and synchronizer flops cleared; synchronizer flops reset to 1, meaning released.
- Column sync: two-flop synchronizer on cols_n. cols = ~sync output, active-high, 2-cycle latency.
- Row drive: rows_n = ~(1 << row_idx). row_idx 0 maps to key_r bit 0; row_idx 3 maps to key_r bit 3.
- SCAN:
  - settle_cnt increments each cycle.
  - At settle_cnt == SETTLE_CYCLES-1, cols is sampled:
    - Exactly one bit set: capture cand_c=cols and cand_r=onehot(row_idx), clear db_cnt, go to DEBOUNCE. The row is held.
    - Zero bits, or two or more bits (ghost/multi-press): row_idx advances (3 wraps to 0), settle_cnt=0, stay in SCAN.
- DEBOUNCE:
  - If cols == cand_c: db_cnt increments.
  - Otherwise: return to SCAN with row_idx advanced and settle_cnt=0; key_valid is never asserted.
  - At db_cnt == DEBOUNCE_CYCLES-1 with cols == cand_c: go to HELD, load key_r=cand_r and key_c=cand_c, and assert key_valid for exactly that one cycle.
- HELD:
  - key_held=1 and the row stays driven.
  - If (cols & key_c) == 0: go to RELEASE with db_cnt=0.
  - Other columns asserting is ignored; one key at a time, no rollover.
- RELEASE:
  - If (cols & key_c) != 0: return to HELD with no new key_valid.
  - Otherwise db_cnt increments. At DEBOUNCE_CYCLES-1: go to SCAN, key_held=0, row_idx advanced.
- key_r/key_c hold the last accepted key until the next acceptance, so the decoder output stays stable between presses.
- Latency from a clean stable press on the scanned row to key_valid: 2 (sync) + settle remainder + DEBOUNCE_CYCLES cycles.
- Counter widths: $clog2 of the respective parameter. Counters saturate-free because every terminal count exits the state.
- key_valid is registered and never high in two consecutive cycles.

Decomposition:
- Shared package kp_pkg:
  - scan_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - localparam NUM_ROWS=4, NUM_COLS=4.
- Sub-module sync_2ff, parameterised width, reset value all-ones. Instantiated once for cols_n.
- The decode of key_r/key_c to hex stays in the existing decode block. Nothing is duplicated here.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8):
1. Reset held low 3 cycles, then released, no keys pressed:
   - During reset: rows_n=1110, key_r=0, key_c=0, key_valid=0.
   - After release: rows_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, each row for 4 cycles.
2. Key "5" pressed (cols_n bit1 low only while rows_n=1011), held 100 cycles:
   - One key_valid pulse with key_r=0100, key_c=0010.
   - key_held=1 until release debounce completes.
   - rows_n frozen at 1011 while held.
3. Bounce: key "A" asserted for 5 cycles, released for 2, then stable:
   - No key_valid during the bounce.
   - Exactly one key_valid after 8 stable cycles, with key_r=1000, key_c=1000.
4. Release glitch: while "A" is held, column released for 3 cycles then reasserted:
   - Returns to HELD with no second key_valid. key_held stays 1.
5. Two columns low on the same row (keys "7" and "8", rows_n=1101):
   - Scanning continues and no key_valid is issued.
   - With "3" held, pressing "5" has no effect: key_r/key_c stay 1000/0100.
6. reset asserted mid-DEBOUNCE of key "0":
   - Next cycle: state SCAN, rows_n=1110, key_valid=0, key_held=0, key_r/key_c=0.
   - After reset deasserts with "0" still pressed, the press is re-debounced and a fresh key_valid is issued with key_r=0001, key_c=0010.
